// File: rtl/mmcm_ps_servo.sv
// Phase-shift servo: turns the filtered signed phase error into single MMCM fine-phase steps,
// with deadband, step-count clamp, psdone timeout and post-step settle delay.
module mmcm_ps_servo #(
  parameter int WIDTH     = 32,
  parameter int DEADBAND  = 256,
  parameter int MAX_STEPS = 1023,
  parameter int CNT_W     = 16,
  parameter int SETTLE    = 64,
  parameter int TIMEOUT   = 1024
) (
  input  logic                    clk,
  input  logic                    reset_in,
  input  logic                    enable,
  input  logic signed [WIDTH-1:0] err_in,
  input  logic                    err_valid,
  input  logic                    psdone,
  output logic                    psen,
  output logic                    psincdec,
  output logic                    ps_busy,
  output logic signed [CNT_W-1:0] ps_count,
  output logic                    at_limit,
  output logic                    timeout_err
);

  // state     | meaning
  // S_IDLE    | evaluate err_in against deadband and clamp
  // S_REQ     | psen high for one cycle, direction latched
  // S_WAIT    | waiting for psdone, timeout counter running down
  // S_SETTLE  | fixed delay so the filter sees the new phase
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_SETTLE} state_t;

  localparam int CMAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic signed [WIDTH-1:0] DB_POS  = WIDTH'(DEADBAND);
  localparam logic signed [WIDTH-1:0] DB_NEG  = -DB_POS;
  localparam logic signed [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STEPS);
  localparam logic signed [CNT_W-1:0] CNT_MIN = -CNT_MAX;

  state_t                    state_q, state_d;
  logic                      dir_q, dir_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic signed [CNT_W-1:0]   count_d;
  logic                      tmo_set;

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      cnt_q       <= '0;
      ps_count    <= '0;
      at_limit    <= 1'b0;
      timeout_err <= 1'b0;
      psen        <= 1'b0;
      ps_busy     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      ps_count    <= count_d;
      at_limit    <= (count_d == CNT_MAX) || (count_d == CNT_MIN);
      timeout_err <= timeout_err | tmo_set;
      psen        <= (state_d == S_REQ);
      ps_busy     <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    count_d = ps_count;
    tmo_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && err_valid) begin
          if ((err_in > DB_POS) && (ps_count != CNT_MAX)) begin
            dir_d   = 1'b1;
            state_d = S_REQ;
          end else if ((err_in < DB_NEG) && (ps_count != CNT_MIN)) begin
            dir_d   = 1'b0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d   = CW'(TIMEOUT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // psdone wins over expiry when both land on the last cycle
        if (psdone) begin
          count_d = dir_q ? (ps_count + CNT_W'(1)) : (ps_count - CNT_W'(1));
          cnt_d   = CW'(SETTLE - 1);
          state_d = S_SETTLE;
        end else if (cnt_q == '0) begin
          tmo_set = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign psincdec = dir_q;

endmodule

// File: tb/tb_mmcm_ps_servo.sv
// Self-checking bench for mmcm_ps_servo: directed scenarios followed by random steps,
// checked against a transaction-level model of the step count and sticky timeout.
module tb_mmcm_ps_servo;
  localparam int WIDTH     = 32;
  localparam int DEADBAND  = 256;
  localparam int MAX_STEPS = 3;
  localparam int CNT_W     = 16;
  localparam int SETTLE    = 4;
  localparam int TIMEOUT   = 12;

  logic clk = 1'b0;
  logic reset_in = 1'b0;
  logic enable = 1'b0;
  logic err_valid = 1'b0;
  logic psdone = 1'b0;
  logic signed [WIDTH-1:0] err_in = '0;
  logic psen, psincdec, ps_busy, at_limit, timeout_err;
  logic signed [CNT_W-1:0] ps_count;

  int checks = 0;
  int failures = 0;
  int m_cnt = 0;
  bit m_tmo = 1'b0;

  mmcm_ps_servo #(
    .WIDTH(WIDTH), .DEADBAND(DEADBAND), .MAX_STEPS(MAX_STEPS),
    .CNT_W(CNT_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_in(reset_in), .enable(enable), .err_in(err_in),
    .err_valid(err_valid), .psdone(psdone), .psen(psen), .psincdec(psincdec),
    .ps_busy(ps_busy), .ps_count(ps_count), .at_limit(at_limit),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cnt32();
    return int'(ps_count);
  endfunction

  function automatic bit lim();
    return (m_cnt == MAX_STEPS) || (m_cnt == -MAX_STEPS);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_in = 1'b0; err_valid = 1'b0; psdone = 1'b0;
    #1;
    m_cnt = 0; m_tmo = 1'b0;
    chk("rst_psen", psen, 0);
    chk("rst_dir", psincdec, 0);
    chk("rst_busy", ps_busy, 0);
    chk("rst_count", cnt32(), 0);
    chk("rst_limit", at_limit, 0);
    chk("rst_tmo", timeout_err, 0);
    @(negedge clk);
    reset_in = 1'b1;
  endtask

  // One evaluation: present err for one cycle, answer psdone dly cycles after psen
  // (dly > TIMEOUT means psdone is never returned).
  task automatic step(input int err, input bit en, input int dly);
    bit up, dn, go;
    up = err > DEADBAND;
    dn = err < -DEADBAND;
    go = en && ((up && m_cnt < MAX_STEPS) || (dn && m_cnt > -MAX_STEPS));
    @(negedge clk);
    enable = en; err_in = err; err_valid = 1'b1;
    @(negedge clk);
    err_valid = 1'b0;
    chk("psen", psen, go);
    if (!go) begin
      chk("busy_idle", ps_busy, 0);
      chk("count_hold", cnt32(), m_cnt);
      return;
    end
    chk("dir", psincdec, up);
    chk("busy_req", ps_busy, 1);
    if (dly <= TIMEOUT) begin
      for (int k = 1; k <= dly; k++) begin
        @(negedge clk);
        chk("wait_psen", psen, 0);
        chk("wait_dir", psincdec, up);
        if (k == dly) psdone = 1'b1;
      end
      @(negedge clk);
      psdone = 1'b0;
      m_cnt += up ? 1 : -1;
      chk("count", cnt32(), m_cnt);
      chk("limit", at_limit, lim());
      chk("busy_settle", ps_busy, 1);
      for (int i = 1; i < SETTLE; i++) begin
        @(negedge clk);
        chk("settle_busy", ps_busy, 1);
        chk("settle_psen", psen, 0);
      end
      @(negedge clk);
      chk("settle_end", ps_busy, 0);
    end else begin
      for (int k = 1; k <= TIMEOUT; k++) begin
        @(negedge clk);
        chk("tmo_busy", ps_busy, 1);
        chk("tmo_early", timeout_err, m_tmo);
      end
      @(negedge clk);
      m_tmo = 1'b1;
      chk("tmo_idle", ps_busy, 0);
      chk("tmo_flag", timeout_err, 1);
      chk("tmo_count", cnt32(), m_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int err, dly, sel;
    bit en, seen;
    do_reset();

    // basic increment, psdone 5 cycles after psen
    step(1000, 1'b1, 5);

    // deadband boundaries and decrement
    do_reset();
    step(256, 1'b1, 3);
    step(-256, 1'b1, 3);
    step(-257, 1'b1, 3);

    // clamp at +MAX_STEPS, then back off
    do_reset();
    for (int i = 0; i < MAX_STEPS + 2; i++) step(1000, 1'b1, 2);
    chk("clamp_count", cnt32(), MAX_STEPS);
    chk("clamp_limit", at_limit, 1);
    step(-1000, 1'b1, 2);
    chk("unclamp_limit", at_limit, 0);

    // timeout then normal recovery; psdone exactly at expiry counts as done
    do_reset();
    step(1000, 1'b1, TIMEOUT + 1);
    step(1000, 1'b1, 4);
    step(-1000, 1'b1, TIMEOUT);
    chk("tmo_sticky", timeout_err, 1);

    // reset in the middle of WAIT, then a stray psdone
    do_reset();
    @(negedge clk); enable = 1'b1; err_in = 1000; err_valid = 1'b1;
    @(negedge clk); err_valid = 1'b0;
    @(negedge clk);
    do_reset();
    psdone = 1'b1;
    @(negedge clk); psdone = 1'b0;
    @(negedge clk);
    chk("late_done_count", cnt32(), 0);
    chk("late_done_busy", ps_busy, 0);
    chk("late_done_psen", psen, 0);

    // disabled: no steps, stray psdone ignored
    step(5000, 1'b0, 3);
    @(negedge clk); psdone = 1'b1;
    @(negedge clk); psdone = 1'b0;
    @(negedge clk);
    chk("stray_done_count", cnt32(), m_cnt);
    chk("stray_done_tmo", timeout_err, 0);

    // enable dropped mid-step: step completes, nothing further issued
    @(negedge clk); enable = 1'b1; err_in = 1000; err_valid = 1'b1;
    @(negedge clk); chk("mid_psen", psen, 1); enable = 1'b0;
    @(negedge clk); @(negedge clk); psdone = 1'b1;
    @(negedge clk); psdone = 1'b0;
    m_cnt += 1;
    seen = 1'b0;
    for (int i = 0; i < SETTLE + 6; i++) begin
      @(negedge clk);
      if (psen) seen = 1'b1;
    end
    err_valid = 1'b0;
    chk("mid_count", cnt32(), m_cnt);
    chk("mid_no_psen", seen, 0);

    // random steps against the model
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: err = $urandom_range(0, 2 * DEADBAND) - DEADBAND;
        1: err = DEADBAND + 1 + $urandom_range(0, 5000);
        2: err = -DEADBAND - 1 - $urandom_range(0, 5000);
        3: err = ($urandom_range(0, 1) == 1) ? DEADBAND + 1 : -DEADBAND - 1;
        default: err = int'($urandom);
      endcase
      en  = ($urandom_range(0, 5) != 0);
      dly = $urandom_range(1, TIMEOUT + 3);
      step(err, en, dly);
    end
    chk("final_count", cnt32(), m_cnt);
    chk("final_limit", at_limit, lim());
    chk("final_tmo", timeout_err, m_tmo);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
